tdm_frame_receiver: RTL

Receive end of the 8-slot time-division word link: accepts a stream of 16-bit words tagged with a start-of-frame marker and steers slot k of each frame into holding register k (demultiplexing in time). It sits opposite the 8-way word transmitter, which serializes eight words through an 8-way selector. The block presents each completed frame as one 128-bit word under a valid/ready handshake. It holds the frame until the consumer takes it.

---
 rtl/tdm_frame_receiver_if.sv | 28 ++
 rtl/tdm_frame_receiver.sv | 103 ++++++++++
 2 files changed

// File: rtl/tdm_frame_receiver_if.sv
// Word-in / frame-out bundle for the 8-slot TDM frame receiver.
// Latency: none (wires only).
// Backpressure: in_ready and frame_ready carry the two valid/ready handshakes.
interface tdm_frame_receiver_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_sof;
  logic [WIDTH-1:0]   in_data;
  logic               in_ready;
  logic               frame_valid;
  logic               frame_ready;
  logic [8*WIDTH-1:0] out_frame;
  logic [2:0]         slot_idx;
  logic               err_sof;

  // word source and frame consumer side
  modport master (
    output in_valid, in_sof, in_data, frame_ready,
    input  in_ready, frame_valid, out_frame, slot_idx, err_sof
  );

  // receiver side
  modport slave (
    input  in_valid, in_sof, in_data, frame_ready,
    output in_ready, frame_valid, out_frame, slot_idx, err_sof
  );
endinterface

// File: rtl/tdm_frame_receiver.sv
// Demultiplexes SOF-tagged 16-bit slot words into an 8-slot 128-bit frame.
// Latency: frame_valid rises the cycle after slot 7 is accepted.
// Backpressure: in_ready drops while a completed frame waits for frame_ready.
// Optional: define TDM_SOF_RESYNC_EN to restart the frame on a mid-frame SOF
// instead of dropping it.
module tdm_frame_receiver #(
  parameter int WIDTH = 16
) (
  input logic                clk,
  input logic                rst_n,
  tdm_frame_receiver_if.slave bus
);

  localparam int SLOTS = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                 state;
  logic [SLOTS*WIDTH-1:0] frame_q;
  logic [2:0]             slot_idx_q;
  logic                   frame_valid_q;
  logic                   err_sof_q;
  logic                   in_ready;
  logic                   accept;

  // Ready is a pure decode of registered state, held low while in reset.
  assign in_ready = rst_n && (state != HOLD);
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready    = in_ready;
  assign bus.frame_valid = frame_valid_q;
  assign bus.out_frame   = frame_q;
  assign bus.slot_idx    = slot_idx_q;
  assign bus.err_sof     = err_sof_q;

  // Frame FSM plus slot write; only the addressed slot register changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      frame_q       <= '0;
      slot_idx_q    <= '0;
      frame_valid_q <= 1'b0;
      err_sof_q     <= 1'b0;
    end else begin
      err_sof_q <= 1'b0;
      case (state)
        IDLE: begin
          // words without SOF are stray data and are dropped quietly
          if (accept && bus.in_sof) begin
            frame_q[0 +: WIDTH] <= bus.in_data;
            slot_idx_q          <= 3'd1;
            state               <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            if (bus.in_sof) begin
              err_sof_q <= 1'b1;
`ifdef TDM_SOF_RESYNC_EN
              // treat the new SOF as the true frame start
              frame_q[0 +: WIDTH] <= bus.in_data;
              slot_idx_q          <= 3'd1;
`else
              // abandon the partial frame and wait for the next SOF
              slot_idx_q <= 3'd0;
              state      <= IDLE;
`endif
            end else begin
              for (int k = 1; k < SLOTS; k++) begin
                if (slot_idx_q == 3'(k)) begin
                  frame_q[k*WIDTH +: WIDTH] <= bus.in_data;
                end
              end
              if (slot_idx_q == 3'(SLOTS - 1)) begin
                slot_idx_q    <= 3'd0;
                frame_valid_q <= 1'b1;
                state         <= HOLD;
              end else begin
                slot_idx_q <= slot_idx_q + 3'd1;
              end
            end
          end
        end
        HOLD: begin
          if (bus.frame_ready) begin
            frame_valid_q <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          slot_idx_q    <= 3'd0;
          frame_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
